// File: rtl/timer_run_control_if.sv
// Button/display bundle between the user panel and timer_run_control.
// Ports: start_stop/clear/lap button levels in; count/running/lap_active/wrap out.
interface timer_run_control_if;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [7:0] count;
    logic       running;
    logic       lap_active;
    logic       wrap;

    modport master (
        output start_stop, clear, lap,
        input  count, running, lap_active, wrap
    );

    modport slave (
        input  start_stop, clear, lap,
        output count, running, lap_active, wrap
    );
endinterface

// File: rtl/timer_run_control.sv
// Run/pause/clear control, 1 Hz prescaler and lap hold for the 0..99 s timer.
// Ports: clk_50MHz, reset (sync, active high), bus (slave: buttons in, display out).
module timer_run_control #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MAX_COUNT = 99
) (
    input  logic                clk_50MHz,
    input  logic                reset,
    timer_run_control_if.slave  bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    CNT_MAX  = 8'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Button order in the vectors: [0]=start_stop, [1]=clear, [2]=lap
    logic [2:0] w_btn;
    logic [2:0] r_s1;
    logic [2:0] r_s2;
    logic [2:0] r_s3;
    logic [2:0] r_press;
    logic [1:0] r_warm;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_pre;
    logic [PW-1:0] w_pre_nxt;
    logic [7:0]    r_live;
    logic [7:0]    w_live_nxt;
    logic [7:0]    r_lap;
    logic [7:0]    w_lap_nxt;
    logic          r_lapa;
    logic          w_lapa_nxt;
    logic          w_wrap_nxt;
    logic          w_tick;

    logic [7:0]    r_count;
    logic          r_running;
    logic          r_wrap;

    assign w_btn = {bus.lap, bus.clear, bus.start_stop};

    // Edge detection stays disabled until the synchroniser holds real
    // samples, so a button held through reset is never seen as a press.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_press <= '0;
            r_warm  <= '0;
        end else begin
            r_s1    <= w_btn;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_press <= (r_warm == 2'd3) ? (r_s2 & ~r_s3) : 3'b000;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pre     <= '0;
            r_live    <= '0;
            r_lap     <= '0;
            r_lapa    <= 1'b0;
            r_wrap    <= 1'b0;
            r_running <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre     <= w_pre_nxt;
            r_live    <= w_live_nxt;
            r_lap     <= w_lap_nxt;
            r_lapa    <= w_lapa_nxt;
            r_wrap    <= w_wrap_nxt;
            r_running <= (w_state_nxt == RUN);
            r_count   <= r_lapa ? r_lap : r_live;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_live_nxt  = r_live;
        w_lap_nxt   = r_lap;
        w_lapa_nxt  = r_lapa;
        w_wrap_nxt  = 1'b0;
        w_tick      = 1'b0;

        // The prescaler advances on the current state, so a tick on the
        // same edge as RUN->PAUSE still counts.
        if (r_state == RUN) begin
            if (r_pre == PRE_LAST) begin
                w_pre_nxt = '0;
                w_tick    = 1'b1;
            end else begin
                w_pre_nxt = r_pre + 1'b1;
            end
        end

        if (w_tick) begin
            if (r_live >= CNT_MAX) begin
                w_live_nxt = '0;
                w_wrap_nxt = 1'b1;
            end else begin
                w_live_nxt = r_live + 8'd1;
            end
        end

        if (r_press[1]) begin
            w_state_nxt = IDLE;
            w_pre_nxt   = '0;
            w_live_nxt  = '0;
            w_lap_nxt   = '0;
            w_lapa_nxt  = 1'b0;
            w_wrap_nxt  = 1'b0;
        end else begin
            if (r_press[0]) begin
                unique case (r_state)
                    IDLE:    w_state_nxt = RUN;
                    RUN:     w_state_nxt = PAUSE;
                    PAUSE:   w_state_nxt = RUN;
                    default: w_state_nxt = IDLE;
                endcase
            end
            // Lap captures the post-tick live value
            if (r_press[2] && (r_state != IDLE)) begin
                if (r_lapa) begin
                    w_lapa_nxt = 1'b0;
                end else begin
                    w_lapa_nxt = 1'b1;
                    w_lap_nxt  = w_live_nxt;
                end
            end
        end
    end

    assign bus.count      = r_count;
    assign bus.running    = r_running;
    assign bus.lap_active = r_lapa;
    assign bus.wrap       = r_wrap;

endmodule

// File: tb/tb_timer_run_control.sv
// Directed bench for timer_run_control with TICK_DIV=4, MAX_COUNT=99.
// Expected display states are queued, then popped and compared at negedges.
module tb_timer_run_control;

    logic clk;
    logic reset;

    timer_run_control_if u_if ();

    timer_run_control #(
        .TICK_DIV  (4),
        .MAX_COUNT (99)
    ) dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .bus       (u_if)
    );

    typedef struct {
        string      tag;
        logic [7:0] c;
        logic       r;
        logic       l;
        logic       w;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [7:0] c,
                        input logic r, input logic l, input logic w);
        exp_t e;
        e.tag = tag;
        e.c   = c;
        e.r   = r;
        e.l   = l;
        e.w   = w;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        assert ({u_if.count, u_if.running, u_if.lap_active, u_if.wrap}
                === {e.c, e.r, e.l, e.w})
        else begin
            n_errors++;
            $error("FAIL %s: observed count=%0d running=%0b lap_active=%0b wrap=%0b, expected count=%0d running=%0b lap_active=%0b wrap=%0b",
                   e.tag, u_if.count, u_if.running, u_if.lap_active, u_if.wrap,
                   e.c, e.r, e.l, e.w);
        end
    endtask

    // Queue the expectation, let n cycles pass, then compare
    task automatic step(input int n, input string tag, input logic [7:0] c,
                        input logic r, input logic l, input logic w);
        push(tag, c, r, l, w);
        cyc(n);
        check();
    endtask

    // One-cycle button pulse; returns at the negedge after it was sampled
    task automatic press(input logic s, input logic c, input logic l);
        u_if.start_stop = s;
        u_if.clear      = c;
        u_if.lap        = l;
        @(negedge clk);
        u_if.start_stop = 1'b0;
        u_if.clear      = 1'b0;
        u_if.lap        = 1'b0;
    endtask

    // Stops at the first negedge where count shows v
    task automatic wait_count(input logic [7:0] v, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (u_if.count == v) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        assert (found)
        else begin
            n_errors++;
            $error("FAIL wait_count: observed count=%0d, expected %0d within %0d cycles",
                   u_if.count, v, budget);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        u_if.start_stop = 1'b0;
        u_if.clear      = 1'b0;
        u_if.lap        = 1'b0;
        cyc(3);

        step(0, "reset_state", 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(4);

        // Start; count 0,1,2 every 4 cycles
        press(1'b1, 1'b0, 1'b0);
        step(3, "start_run", 8'd0, 1'b1, 1'b0, 1'b0);
        step(4, "pre_tick1", 8'd0, 1'b1, 1'b0, 1'b0);
        step(1, "tick1", 8'd1, 1'b1, 1'b0, 1'b0);
        cyc(1);

        // Pause two cycles into a tick period
        press(1'b1, 1'b0, 1'b0);
        step(2, "tick2", 8'd2, 1'b1, 1'b0, 1'b0);
        step(1, "pause", 8'd2, 1'b0, 1'b0, 1'b0);
        step(8, "pause_hold", 8'd2, 1'b0, 1'b0, 1'b0);

        // Resume finishes the partial second
        press(1'b1, 1'b0, 1'b0);
        step(3, "resume", 8'd2, 1'b1, 1'b0, 1'b0);
        step(2, "resume_pre", 8'd2, 1'b1, 1'b0, 1'b0);
        step(1, "resume_tick", 8'd3, 1'b1, 1'b0, 1'b0);

        // Lap freeze at 12 while live runs on to 15
        wait_count(8'd11, 100);
        press(1'b0, 1'b0, 1'b1);
        step(3, "lap_on", 8'd12, 1'b1, 1'b1, 1'b0);
        step(10, "lap_hold", 8'd12, 1'b1, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        step(2, "lap_hold2", 8'd12, 1'b1, 1'b1, 1'b0);
        step(1, "lap_off", 8'd12, 1'b1, 1'b0, 1'b0);
        step(1, "lap_live", 8'd15, 1'b1, 1'b0, 1'b0);

        // Lap set, then clear+start together wins as clear
        wait_count(8'd38, 200);
        press(1'b0, 1'b0, 1'b1);
        step(8, "lap_39", 8'd39, 1'b1, 1'b1, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        step(3, "clear_state", 8'd39, 1'b0, 1'b0, 1'b0);
        step(1, "clear_count", 8'd0, 1'b0, 1'b0, 1'b0);
        step(8, "idle_hold", 8'd0, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        step(6, "idle_lap", 8'd0, 1'b0, 1'b0, 1'b0);

        // Start held across reset is not a press
        reset           = 1'b1;
        u_if.start_stop = 1'b1;
        step(3, "reset_held", 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(10, "held_nopress", 8'd0, 1'b0, 1'b0, 1'b0);
        u_if.start_stop = 1'b0;
        step(4, "release", 8'd0, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        step(3, "restart", 8'd0, 1'b1, 1'b0, 1'b0);

        // Wrap 99 -> 0 with a single wrap pulse
        wait_count(8'd99, 1000);
        step(2, "at_99", 8'd99, 1'b1, 1'b0, 1'b0);
        step(1, "wrap_pulse", 8'd99, 1'b1, 1'b0, 1'b1);
        step(1, "wrap_zero", 8'd0, 1'b1, 1'b0, 1'b0);
        step(1, "wrap_single", 8'd0, 1'b1, 1'b0, 1'b0);

        // Reset mid-run at 57
        wait_count(8'd57, 500);
        reset = 1'b1;
        step(1, "reset_at57", 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(10, "post_reset", 8'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
